// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// instruction-fetch and data requesters, with a simple req/ack handshake on each side.
module mem_arbiter #(
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;  // 1 = data port; also the active grant
  logic [CW-1:0] cnt_q, cnt_d;

  logic          if_ack_q, if_ack_d;
  logic          if_err_q, if_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-3:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          grant_data;
  logic [AW-1:0] sel_addr;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    // With both pending, the port that did not win last time gets the grant.
    grant_data   = d_req && (!if_req || !last_grant_q);
    sel_addr     = grant_data ? d_addr : if_addr;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          last_grant_d = grant_data;
          if (sel_addr[1:0] != 2'b00) begin
            state_d  = StAck;
            if_ack_d = !grant_data;
            if_err_d = !grant_data;
            d_ack_d  = grant_data;
            d_err_d  = grant_data;
          end else begin
            state_d    = StIssue;
            mem_en_d   = 1'b1;
            mem_addr_d = sel_addr[AW-1:2];
            mem_we_d   = grant_data && d_we;
            if (grant_data) mem_wdata_d = d_wdata;
          end
        end
      end
      StIssue: begin
        cnt_d   = CW'(MEM_LAT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StAck;
          if (last_grant_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-latency instance on a behavioural memory,
// plus a MEM_LAT=1 instance driven by hand.
module tb_mem_arbiter;

  localparam logic [31:0] Sentinel = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [9:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_ack, if_err, d_ack, d_err, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic        if_req1;
  logic [9:0]  if_addr1;
  logic        if_ack1, if_err1, d_ack1, d_err1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [7:0]  mem_addr1;

  int n_vec = 0;
  int n_err = 0;
  int n_if_ack, n_d_ack, n_both;

  mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .if_err(if_err1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(10'h000), .d_wdata(32'h0),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  // Behavioural memory: read data appears two cycles after the mem_en cycle, sentinel otherwise.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [1:0]  rd_v = 2'b00;
  logic [7:0]  rd_a0, rd_a1;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rd_v  <= {rd_v[0], mem_en && !mem_we};
    rd_a0 <= mem_addr;
    rd_a1 <= rd_a0;
  end

  assign mem_rdata = rd_v[1] ? mem[rd_a1] : Sentinel;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; mem_rdata1 = Sentinel;
    pre_we = 1'b1; pre_addr = 8'd4; pre_data = 32'hDEAD_BEEF;
    step();
    pre_we = 1'b0;
    step();
    chk("rst mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst acks", {30'b0, if_ack, d_ack}, 32'd0);
    chk("rst errs", {30'b0, if_err, d_err}, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Fetch read of byte 0x010 (word 4).
    if_req = 1'b1; if_addr = 10'h010;
    step();
    chk("fetch c1 mem_en", {31'b0, mem_en}, 32'd1);
    chk("fetch c1 mem_addr", {24'b0, mem_addr}, 32'd4);
    chk("fetch c1 mem_we", {31'b0, mem_we}, 32'd0);
    step();
    chk("fetch c2 mem_en", {31'b0, mem_en}, 32'd0);
    step();
    chk("fetch c3 if_ack", {31'b0, if_ack}, 32'd0);
    step();
    chk("fetch c4 if_ack", {31'b0, if_ack}, 32'd1);
    chk("fetch c4 if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("fetch c4 if_err/d_ack", {30'b0, if_err, d_ack}, 32'd0);
    if_req = 1'b0;
    step();
    chk("fetch c5 if_ack", {31'b0, if_ack}, 32'd0);

    // Store 0x12345678 to byte 0x020 (word 8).
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'h1234_5678;
    step();
    chk("store c1 mem_en/we", {30'b0, mem_en, mem_we}, 32'd3);
    chk("store c1 mem_addr", {24'b0, mem_addr}, 32'd8);
    chk("store c1 mem_wdata", mem_wdata, 32'h1234_5678);
    step(); step(); step();
    chk("store c4 d_ack/err", {30'b0, d_ack, d_err}, 32'd2);
    chk("store c4 d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    step();

    // Load it back.
    d_req = 1'b1; d_we = 1'b0;
    step();
    chk("load c1 mem_en/we", {30'b0, mem_en, mem_we}, 32'd2);
    step(); step(); step();
    chk("load c4 d_ack", {31'b0, d_ack}, 32'd1);
    chk("load c4 d_rdata", d_rdata, 32'h1234_5678);
    chk("load c4 if_rdata held", if_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();

    // Misaligned data access.
    d_req = 1'b1; d_addr = 10'h003;
    step();
    chk("misal c1 d_ack/err", {30'b0, d_ack, d_err}, 32'd3);
    chk("misal c1 mem_en", {31'b0, mem_en}, 32'd0);
    chk("misal c1 d_rdata", d_rdata, 32'h1234_5678);
    d_req = 1'b0;
    step();
    chk("misal c2 d_ack/err/en", {29'b0, d_ack, d_err, mem_en}, 32'd0);

    // Reset, then contention: expect I, D, I, D.
    rst_n = 1'b0;
    step();
    chk("rst2 d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 10'h010; d_req = 1'b1; d_addr = 10'h020; d_we = 1'b0;
    n_if_ack = 0; n_d_ack = 0; n_both = 0;
    for (int c = 1; c <= 19; c++) begin
      step();
      n_if_ack += int'(if_ack);
      n_d_ack  += int'(d_ack);
      n_both   += int'(if_ack && d_ack);
      if (c == 4) begin
        chk("cont c4 acks", {30'b0, if_ack, d_ack}, 32'd2);
        chk("cont c4 if_rdata", if_rdata, 32'hDEAD_BEEF);
      end
      if (c == 6) chk("cont c6 mem_en/addr", {23'b0, mem_en, mem_addr}, 32'h108);
      if (c == 9) begin
        chk("cont c9 acks", {30'b0, if_ack, d_ack}, 32'd1);
        chk("cont c9 d_rdata", d_rdata, 32'h1234_5678);
      end
      if (c == 11) chk("cont c11 mem_en/addr", {23'b0, mem_en, mem_addr}, 32'h104);
      if (c == 14) begin
        chk("cont c14 acks", {30'b0, if_ack, d_ack}, 32'd2);
        if_req = 1'b0;
      end
      if (c == 19) begin
        chk("cont c19 acks", {30'b0, if_ack, d_ack}, 32'd1);
        d_req = 1'b0;
      end
    end
    chk("cont if_ack count", n_if_ack, 32'd2);
    chk("cont d_ack count", n_d_ack, 32'd2);
    chk("cont overlap count", n_both, 32'd0);
    step();

    // Reset in the first WAIT cycle of a fetch.
    if_req = 1'b1; if_addr = 10'h010;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midrst if_ack", {31'b0, if_ack}, 32'd0);
    chk("midrst if_rdata", if_rdata, 32'd0);
    chk("midrst mem_en/addr", {23'b0, mem_en, mem_addr}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst c1 mem_en/addr", {23'b0, mem_en, mem_addr}, 32'h104);
    step(); step();
    chk("midrst c3 if_ack", {31'b0, if_ack}, 32'd0);
    step();
    chk("midrst c4 if_ack", {31'b0, if_ack}, 32'd1);
    chk("midrst c4 if_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    step();

    // MEM_LAT=1 instance: fetch of byte 0x000.
    if_req1 = 1'b1; if_addr1 = 10'h000;
    step();
    chk("lat1 c1 mem_en/addr", {23'b0, mem_en1, mem_addr1}, 32'h100);
    step();
    mem_rdata1 = 32'hA5A5_0001;
    chk("lat1 c2 if_ack", {31'b0, if_ack1}, 32'd0);
    step();
    mem_rdata1 = Sentinel;
    chk("lat1 c3 if_ack/err", {30'b0, if_ack1, if_err1}, 32'd2);
    chk("lat1 c3 if_rdata", if_rdata1, 32'hA5A5_0001);
    if_req1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
